// File: rtl/obstacle_field_generator.sv
// Scrolling obstacle field for a runner game: an LFSR picks spawn columns
// that enter at the top bit and shift one column toward bit 0 per tick.
module obstacle_field_generator #(
  parameter int WIDTH = 16,
  parameter int LFSR_W = 16,
  parameter int MIN_GAP = 3,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tick,
  input  logic [4:0]        spawn_prob,
  input  logic              air_en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [WIDTH-1:0]  ground,
  output logic [WIDTH-1:0]  air,
  output logic              spawned,
  output logic [7:0]        passed
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  ground_q, ground_d;
  logic [WIDTH-1:0]  air_q, air_d;
  logic [3:0]        gap_q, gap_d;
  logic [7:0]        passed_q, passed_d;
  logic              spawned_q, spawned_d;

  logic fb;
  logic hit;
  logic shift;
  logic to_air;

  assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign hit    = (gap_q >= 4'(MIN_GAP)) &&
                  ({1'b0, lfsr_q[3:0]} < spawn_prob);
  assign to_air = air_en & lfsr_q[4];
  assign shift  = en & tick & ~seed_load;

  always_comb begin
    lfsr_d    = lfsr_q;
    ground_d  = ground_q;
    air_d     = air_q;
    gap_d     = gap_q;
    passed_d  = passed_q;
    spawned_d = 1'b0;
    if (en) begin
      if (seed_load) begin
        lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
      end else begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
      end
    end
    if (shift) begin
      // Decisions use the LFSR value from before this cycle's advance
      ground_d  = {hit & ~to_air, ground_q[WIDTH-1:1]};
      air_d     = {hit & to_air, air_q[WIDTH-1:1]};
      spawned_d = hit;
      if (hit) begin
        gap_d = 4'd0;
      end else if (gap_q != 4'hF) begin
        gap_d = gap_q + 4'd1;
      end
      if (ground_q[0] | air_q[0]) begin
        passed_d = passed_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= SEED;
      ground_q  <= '0;
      air_q     <= '0;
      gap_q     <= 4'(MIN_GAP);
      passed_q  <= 8'd0;
      spawned_q <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      ground_q  <= ground_d;
      air_q     <= air_d;
      gap_q     <= gap_d;
      passed_q  <= passed_d;
      spawned_q <= spawned_d;
    end
  end

  assign ground  = ground_q;
  assign air     = air_q;
  assign spawned = spawned_q;
  assign passed  = passed_q;

endmodule

// File: tb/tb_obstacle_field_generator.sv
// Bench for obstacle_field_generator: reference model feeds a scoreboard
// queue, plus directed checks of the spawn cadence, seeding and hold.
module tb_obstacle_field_generator;

  logic        clk = 1'b0;
  logic        rst, en, tick, air_en, seed_load;
  logic [4:0]  spawn_prob;
  logic [15:0] seed;
  logic [15:0] ground, air;
  logic        spawned;
  logic [7:0]  passed;

  obstacle_field_generator dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .spawn_prob(spawn_prob), .air_en(air_en),
    .seed_load(seed_load), .seed(seed),
    .ground(ground), .air(air),
    .spawned(spawned), .passed(passed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] g;
    logic [15:0] a;
    logic        s;
    logic [7:0]  p;
    logic [15:0] l;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;

  logic [15:0] m_l, m_g, m_a;
  logic [3:0]  m_gap;
  logic [7:0]  m_p;
  logic        m_s;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic e,
                       input logic t, input logic [4:0] p,
                       input logic ae, input logic sl,
                       input logic [15:0] sd);
    logic hit, ta, sn;
    sn = 1'b0;
    if (r) begin
      m_l = 16'hACE1; m_g = '0; m_a = '0;
      m_gap = 4'd3; m_p = 8'd0;
    end else if (e) begin
      if (sl) begin
        m_l = (sd == 16'd0) ? 16'd1 : sd;
      end else begin
        if (t) begin
          hit = (m_gap >= 4'd3) && ({1'b0, m_l[3:0]} < p);
          ta = ae & m_l[4];
          if (m_g[0] | m_a[0]) m_p = m_p + 8'd1;
          m_g = {hit & ~ta, m_g[15:1]};
          m_a = {hit & ta, m_a[15:1]};
          if (hit) m_gap = 4'd0;
          else if (m_gap != 4'hF) m_gap = m_gap + 4'd1;
          sn = hit;
        end
        m_l = {m_l[14:0], m_l[15] ^ m_l[13] ^ m_l[12] ^ m_l[10]};
      end
    end
    m_s = sn;
  endtask

  task automatic step(input logic r, input logic e,
                      input logic t, input logic [4:0] p,
                      input logic ae, input logic sl,
                      input logic [15:0] sd);
    exp_t x;
    rst = r; en = e; tick = t; spawn_prob = p;
    air_en = ae; seed_load = sl; seed = sd;
    model(r, e, t, p, ae, sl, sd);
    x.g = m_g; x.a = m_a; x.s = m_s; x.p = m_p; x.l = m_l;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      x = q.pop_front();
      check("sb_ground", {16'd0, ground}, {16'd0, x.g});
      check("sb_air", {16'd0, air}, {16'd0, x.a});
      check("sb_spawned", {31'd0, spawned}, {31'd0, x.s});
      check("sb_passed", {24'd0, passed}, {24'd0, x.p});
      check("sb_lfsr", {16'd0, dut.lfsr_q}, {16'd0, x.l});
      check("sb_overlap", {16'd0, ground & air}, 32'd0);
    end
  endtask

  task automatic tk(input logic [4:0] p, input logic ae);
    step(1'b0, 1'b1, 1'b1, p, ae, 1'b0, 16'd0);
  endtask

  logic [4:0]  sp_tab [40];
  logic [31:0] tr [2][40];
  logic [15:0] hold_g, hold_a, hold_l;
  logic [7:0]  hold_p;
  logic        any_spw;
  int          cnt;

  initial begin
    for (int i = 0; i < 40; i++) sp_tab[i] = 5'($urandom_range(0, 31));

    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 16'd0);
    check("rst_ground", {16'd0, ground}, 32'd0);
    check("rst_air", {16'd0, air}, 32'd0);
    check("rst_passed", {24'd0, passed}, 32'd0);
    check("rst_spawned", {31'd0, spawned}, 32'd0);
    check("rst_lfsr", {16'd0, dut.lfsr_q}, 32'hACE1);

    any_spw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tk(5'd0, 1'b1);
      any_spw |= spawned;
    end
    check("p0_ground", {16'd0, ground}, 32'd0);
    check("p0_air", {16'd0, air}, 32'd0);
    check("p0_passed", {24'd0, passed}, 32'd0);
    check("p0_spawned_ever", {31'd0, any_spw}, 32'd0);

    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 16'd0);
    for (int k = 1; k <= 32; k++) begin
      tk(5'd16, 1'b0);
      check("cad_g15", {31'd0, ground[15]},
            {31'd0, ((k - 1) % 4) == 0});
      check("cad_air", {16'd0, air}, 32'd0);
      cnt = int'(k >= 17) + int'(k >= 21) +
            int'(k >= 25) + int'(k >= 29);
      check("cad_passed", {24'd0, passed}, cnt);
      if (k == 8) check("cad_g8", {16'd0, ground}, 32'h1100);
    end
    check("cad_passed32", {24'd0, passed}, 32'd4);

    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 16'd0);
    check("seed0_lfsr", {16'd0, dut.lfsr_q}, 32'd1);

    for (int r = 0; r < 2; r++) begin
      step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 16'd0);
      step(1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 16'h1234);
      check("seed_lfsr", {16'd0, dut.lfsr_q}, 32'h1234);
      for (int i = 0; i < 40; i++) begin
        tk(sp_tab[i], 1'b1);
        tr[r][i] = {ground, air};
      end
    end
    for (int i = 0; i < 40; i++) check("replay", tr[1][i], tr[0][i]);

    for (int i = 0; i < 6; i++) tk(5'd31, 1'b1);
    hold_g = m_g; hold_a = m_a; hold_l = m_l; hold_p = m_p;
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b1, 5'd31, 1'b1, 1'b1, 16'h5A5A);
    check("hold_ground", {16'd0, ground}, {16'd0, hold_g});
    check("hold_air", {16'd0, air}, {16'd0, hold_a});
    check("hold_lfsr", {16'd0, dut.lfsr_q}, {16'd0, hold_l});
    check("hold_passed", {24'd0, passed}, {24'd0, hold_p});
    check("hold_spawned", {31'd0, spawned}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 16'h5A5A);
    check("prio_lfsr", {16'd0, dut.lfsr_q}, 32'h5A5A);
    check("prio_ground", {16'd0, ground}, {16'd0, hold_g});
    check("prio_air", {16'd0, air}, {16'd0, hold_a});
    check("prio_spawned", {31'd0, spawned}, 32'd0);

    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 10; i++) tk(5'd31, 1'b1);
    step(1'b1, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0, 16'd0);
    check("mid_rst_ground", {16'd0, ground}, 32'd0);
    check("mid_rst_air", {16'd0, air}, 32'd0);
    check("mid_rst_lfsr", {16'd0, dut.lfsr_q}, 32'hACE1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
